// File: rtl/csr_regfile.sv
// ---------------------------------------------------------------------------
// csr_regfile
// Machine-mode control and status register file. Answers CSR reads from the
// execute stage combinationally, commits pre-merged CSR write data at the
// clock edge, and holds the trap state (mstatus MIE/MPIE, mepc, mcause) that
// trap entry and mret update.
//
// Optional feature macro: CSR_COUNTERS_EN
//   defined   : 64-bit mcycle/minstret counters plus their R/W (0xB00/0xB80/
//               0xB02/0xB82) and read-only mirror (0xC00/0xC80/0xC02/0xC82)
//               addresses are implemented.
//   undefined : no counter flops; the eight counter addresses read 0 without
//               illegal_o, writes to them are dropped, and writes to the
//               read-only mirrors still flag illegal_o. instret_i is ignored.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   csr_raddr_i/rdata_o    combinational read port
//   csr_we_i/waddr_i/wdata_i  write port, committed at the edge
//   illegal_o              unimplemented read address, or write to an
//                          unimplemented / read-only address
//   trap_i, trap_pc_i, trap_cause_i  trap entry pulse and its payload
//   mret_i                 mret commit pulse
//   instret_i              instruction-retired pulse
//   mtvec_o, mepc_o, mie_o current mtvec, mepc and mstatus.MIE
// ---------------------------------------------------------------------------
module csr_regfile #(
   parameter int unsigned XLEN        = 32,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [11:0]     csr_raddr_i,
   output logic [XLEN-1:0] csr_rdata_o,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_waddr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic            illegal_o,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic            mret_i,
   input  logic            instret_i,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o,
   output logic            mie_o
);

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MISA      = 12'h301;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

   logic        mstatus_mie_q,  mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0] mie_csr_q,      mie_csr_d;
   logic [31:0] mtvec_q,        mtvec_d;
   logic [31:0] mscratch_q,     mscratch_d;
   logic [31:0] mepc_q,         mepc_d;
   logic [31:0] mcause_q,       mcause_d;

   logic [31:0] mstatus_rd_s;
   logic [31:0] rdata_s;
   logic        rd_known_s;
   logic        wr_ok_s;

   // MPP is hard-wired to machine mode, so it always reads 2'b11.
   assign mstatus_rd_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_q,   mcycle_d;
   logic [63:0] minstret_q, minstret_d;
   logic [63:0] mcycle_rd_s;
   logic [63:0] minstret_rd_s;

   assign mcycle_rd_s   = mcycle_q;
   assign minstret_rd_s = minstret_q;
`else
   logic [63:0] mcycle_rd_s;
   logic [63:0] minstret_rd_s;
   logic        unused_instret_s;

   assign mcycle_rd_s      = 64'd0;
   assign minstret_rd_s    = 64'd0;
   assign unused_instret_s = instret_i;
`endif

   // Read mux: zero-latency, always from current register state (no bypass).
   always_comb begin
      rdata_s    = 32'd0;
      rd_known_s = 1'b1;
      case (csr_raddr_i)
         ADDR_MSTATUS:   rdata_s = mstatus_rd_s;
         ADDR_MISA:      rdata_s = MISA_VALUE;
         ADDR_MIE:       rdata_s = mie_csr_q;
         ADDR_MTVEC:     rdata_s = mtvec_q;
         ADDR_MSCRATCH:  rdata_s = mscratch_q;
         ADDR_MEPC:      rdata_s = mepc_q;
         ADDR_MCAUSE:    rdata_s = mcause_q;
         ADDR_MIP:       rdata_s = 32'd0;
         ADDR_MCYCLE,   ADDR_CYCLE:    rdata_s = mcycle_rd_s[31:0];
         ADDR_MCYCLEH,  ADDR_CYCLEH:   rdata_s = mcycle_rd_s[63:32];
         ADDR_MINSTRET, ADDR_INSTRET:  rdata_s = minstret_rd_s[31:0];
         ADDR_MINSTRETH, ADDR_INSTRETH: rdata_s = minstret_rd_s[63:32];
         default: begin
            rdata_s    = 32'd0;
            rd_known_s = 1'b0;
         end
      endcase
   end

   // Write legality: mip and the R/W counter halves accept (and may drop)
   // writes silently; misa and the read-only mirrors do not.
   always_comb begin
      wr_ok_s = 1'b0;
      case (csr_waddr_i)
         ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
         ADDR_MEPC, ADDR_MCAUSE, ADDR_MIP,
         ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH: wr_ok_s = 1'b1;
         default: wr_ok_s = 1'b0;
      endcase
   end

   assign csr_rdata_o = rdata_s;
   assign illegal_o   = ~rd_known_s | (csr_we_i & ~wr_ok_s);

   // Trap state next value: trap beats mret beats a CSR write.
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_csr_d      = mie_csr_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      if (trap_i) begin
         mepc_d         = trap_pc_i & ~32'd3;
         mcause_d       = trap_cause_i;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_i) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (csr_we_i) begin
         case (csr_waddr_i)
            ADDR_MSTATUS: begin
               mstatus_mie_d  = csr_wdata_i[3];
               mstatus_mpie_d = csr_wdata_i[7];
            end
            ADDR_MIE:      mie_csr_d  = csr_wdata_i;
            ADDR_MTVEC:    mtvec_d    = csr_wdata_i & ~32'd3;
            ADDR_MSCRATCH: mscratch_d = csr_wdata_i;
            ADDR_MEPC:     mepc_d     = csr_wdata_i & ~32'd3;
            ADDR_MCAUSE:   mcause_d   = csr_wdata_i;
            default: begin
               mcause_d = mcause_q;
            end
         endcase
      end else begin
         mcause_d = mcause_q;
      end
   end

   // Trap-state and machine CSR registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_csr_q      <= 32'd0;
         mtvec_q        <= MTVEC_RESET;
         mscratch_q     <= 32'd0;
         mepc_q         <= 32'd0;
         mcause_q       <= 32'd0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_csr_q      <= mie_csr_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
      end
   end

`ifdef CSR_COUNTERS_EN
   // Counter next value: a write to either half replaces it and suppresses
   // that cycle's increment entirely; counters ignore trap/mret priority.
   always_comb begin
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = instret_i ? (minstret_q + 64'd1) : minstret_q;
      if (csr_we_i) begin
         case (csr_waddr_i)
            ADDR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_wdata_i};
            ADDR_MCYCLEH:   mcycle_d   = {csr_wdata_i, mcycle_q[31:0]};
            ADDR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_wdata_i};
            ADDR_MINSTRETH: minstret_d = {csr_wdata_i, minstret_q[31:0]};
            default: begin
               mcycle_d = mcycle_q + 64'd1;
            end
         endcase
      end else begin
         mcycle_d = mcycle_q + 64'd1;
      end
   end

   // 64-bit cycle and instret counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mcycle_q   <= 64'd0;
         minstret_q <= 64'd0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`endif

   assign mtvec_o = mtvec_q;
   assign mepc_o  = mepc_q;
   assign mie_o   = mstatus_mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// ---------------------------------------------------------------------------
// tb_csr_regfile
// Self-checking bench for csr_regfile. Expected values are pushed into a
// scoreboard queue when stimulus is driven and popped when the DUT output is
// sampled (1 ns after the driving point, well away from the rising edge).
// ---------------------------------------------------------------------------
module tb_csr_regfile;

   localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_2000;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [11:0] csr_raddr_i;
   logic [31:0] csr_rdata_o;
   logic        csr_we_i;
   logic [11:0] csr_waddr_i;
   logic [31:0] csr_wdata_i;
   logic        illegal_o;
   logic        trap_i;
   logic [31:0] trap_pc_i;
   logic [31:0] trap_cause_i;
   logic        mret_i;
   logic        instret_i;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic        mie_o;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   chk_cnt = 0;
   int   err_cnt = 0;

   csr_regfile #(
      .XLEN        (32),
      .MTVEC_RESET (TB_MTVEC_RESET),
      .MISA_VALUE  (32'h4000_0100)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .csr_raddr_i  (csr_raddr_i),
      .csr_rdata_o  (csr_rdata_o),
      .csr_we_i     (csr_we_i),
      .csr_waddr_i  (csr_waddr_i),
      .csr_wdata_i  (csr_wdata_i),
      .illegal_o    (illegal_o),
      .trap_i       (trap_i),
      .trap_pc_i    (trap_pc_i),
      .trap_cause_i (trap_cause_i),
      .mret_i       (mret_i),
      .instret_i    (instret_i),
      .mtvec_o      (mtvec_o),
      .mepc_o       (mepc_o),
      .mie_o        (mie_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic exp_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic chk_pop(input logic [31:0] got);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk_val("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk_val(e.tag, got, e.val);
      end
   endtask

   // Step to 1 ns after the next rising edge.
   task automatic ptick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      csr_raddr_i = addr;
      exp_push(tag, exp);
      #1;
      chk_pop(csr_rdata_o);
   endtask

   task automatic ill_chk(input string tag, input logic exp);
      exp_push(tag, {31'd0, exp});
      #0;
      chk_pop({31'd0, illegal_o});
   endtask

   task automatic out_chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      exp_push(tag, exp);
      chk_pop(got);
   endtask

   // One-cycle CSR write, same-cycle signals left to the caller to check.
   task automatic wr_start(input logic [11:0] addr, input logic [31:0] data);
      csr_we_i    = 1'b1;
      csr_waddr_i = addr;
      csr_wdata_i = data;
   endtask

   task automatic wr_end();
      csr_we_i    = 1'b0;
      csr_waddr_i = 12'h000;
      csr_wdata_i = 32'd0;
   endtask

   initial begin
      rst_ni       = 1'b1;
      csr_raddr_i  = 12'h300;
      csr_we_i     = 1'b0;
      csr_waddr_i  = 12'h000;
      csr_wdata_i  = 32'd0;
      trap_i       = 1'b0;
      trap_pc_i    = 32'd0;
      trap_cause_i = 32'd0;
      mret_i       = 1'b0;
      instret_i    = 1'b0;
      #1 rst_ni = 1'b0;
      ptick();

      // Reset state, observed while rst_ni is still low.
      rd_chk("rst_mtvec", 12'h305, TB_MTVEC_RESET);
      rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
      rd_chk("rst_misa", 12'h301, 32'h4000_0100);
      out_chk("rst_mtvec_o", mtvec_o, TB_MTVEC_RESET);
      out_chk("rst_mepc_o", mepc_o, 32'd0);
      out_chk("rst_mie_o", {31'd0, mie_o}, 32'd0);
      rd_chk("rst_mscratch", 12'h340, 32'd0);
      #2 rst_ni = 1'b1;
      ptick();

      // mtvec write: same-cycle read is old, next cycle shows low bits cleared.
      wr_start(12'h305, 32'h8000_0103);
      rd_chk("mtvec_same_cycle", 12'h305, TB_MTVEC_RESET);
      ill_chk("mtvec_wr_legal", 1'b0);
      ptick();
      wr_end();
      rd_chk("mtvec_rb", 12'h305, 32'h8000_0100);
      out_chk("mtvec_o", mtvec_o, 32'h8000_0100);

      // mstatus: only MIE/MPIE writable, MPP reads 11.
      wr_start(12'h300, 32'hFFFF_FFFF);
      ptick();
      wr_end();
      rd_chk("mstatus_all_ones", 12'h300, 32'h0000_1888);
      out_chk("mie_o_set", {31'd0, mie_o}, 32'd1);

      // MIE=1, MPIE=0 so trap/mret both move visible bits.
      wr_start(12'h300, 32'h0000_0008);
      ptick();
      wr_end();
      rd_chk("mstatus_mie_only", 12'h300, 32'h0000_1808);

      // Trap entry.
      trap_i       = 1'b1;
      trap_pc_i    = 32'h0000_0106;
      trap_cause_i = 32'h0000_000B;
      ptick();
      trap_i = 1'b0;
      out_chk("trap_mepc_o", mepc_o, 32'h0000_0104);
      out_chk("trap_mie_o", {31'd0, mie_o}, 32'd0);
      rd_chk("trap_mcause", 12'h342, 32'h0000_000B);
      rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);

      // mret return.
      mret_i = 1'b1;
      ptick();
      mret_i = 1'b0;
      out_chk("mret_mie_o", {31'd0, mie_o}, 32'd1);
      rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

      // Collision: trap beats a write to mepc.
      trap_i       = 1'b1;
      trap_pc_i    = 32'h0000_0200;
      trap_cause_i = 32'h0000_0003;
      wr_start(12'h341, 32'hDEAD_0000);
      ptick();
      trap_i = 1'b0;
      wr_end();
      out_chk("coll_trap_mepc_o", mepc_o, 32'h0000_0200);
      rd_chk("coll_trap_mcause", 12'h342, 32'h0000_0003);

      // Collision: mret beats a write to mscratch.
      mret_i = 1'b1;
      wr_start(12'h340, 32'h0000_0055);
      ptick();
      mret_i = 1'b0;
      wr_end();
      rd_chk("coll_mret_mscratch", 12'h340, 32'd0);
      out_chk("coll_mret_mie_o", {31'd0, mie_o}, 32'd1);

      // Plain R/W registers.
      wr_start(12'h340, 32'hA5A5_5A5A);
      ptick();
      wr_start(12'h304, 32'hFFFF_FFFF);
      rd_chk("mscratch_rb", 12'h340, 32'hA5A5_5A5A);
      ptick();
      wr_start(12'h341, 32'h0000_1237);
      rd_chk("mie_csr_rb", 12'h304, 32'hFFFF_FFFF);
      ptick();
      wr_start(12'h344, 32'hFFFF_FFFF);
      ill_chk("mip_wr_legal", 1'b0);
      rd_chk("mepc_rb", 12'h341, 32'h0000_1234);
      ptick();
      wr_end();
      rd_chk("mip_reads_zero", 12'h344, 32'd0);

      // Illegal accesses.
      rd_chk("ill_rd_data", 12'h7C0, 32'd0);
      ill_chk("ill_rd_flag", 1'b1);
      csr_raddr_i = 12'h300;
      wr_start(12'hC00, 32'h1234_5678);
      #1;
      ill_chk("ill_wr_c00", 1'b1);
      wr_start(12'h301, 32'h0000_0000);
      #1;
      ill_chk("ill_wr_misa", 1'b1);
      wr_start(12'h7C0, 32'hFFFF_FFFF);
      #1;
      ill_chk("ill_wr_unimpl", 1'b1);
      ptick();
      wr_end();
      rd_chk("misa_unchanged", 12'h301, 32'h4000_0100);
      rd_chk("mstatus_unchanged", 12'h300, 32'h0000_1888);

`ifdef CSR_COUNTERS_EN
      // mcycle low-word carry into high word.
      wr_start(12'hB80, 32'h0000_0000);
      ptick();
      wr_start(12'hB00, 32'hFFFF_FFFE);
      ptick();
      wr_end();
      rd_chk("cyc0_lo", 12'hB00, 32'hFFFF_FFFE);
      rd_chk("cyc0_hi", 12'hB80, 32'd0);
      ptick();
      rd_chk("cyc1_lo", 12'hB00, 32'hFFFF_FFFF);
      rd_chk("cyc1_hi", 12'hB80, 32'd0);
      ptick();
      rd_chk("cyc2_lo", 12'hB00, 32'd0);
      rd_chk("cyc2_hi", 12'hB80, 32'd1);
      rd_chk("cyc2_mirror_hi", 12'hC80, 32'd1);
      ill_chk("cyc_rd_legal", 1'b0);

      // 64-bit wrap.
      wr_start(12'hB80, 32'hFFFF_FFFF);
      ptick();
      wr_start(12'hB00, 32'hFFFF_FFFF);
      ptick();
      wr_end();
      rd_chk("wrap_pre_hi", 12'hB80, 32'hFFFF_FFFF);
      ptick();
      rd_chk("wrap_lo", 12'hC00, 32'd0);
      rd_chk("wrap_hi", 12'hB80, 32'd0);

      // minstret: write wins over a same-cycle retire pulse.
      instret_i = 1'b1;
      wr_start(12'hB02, 32'h0000_0005);
      ptick();
      wr_end();
      ptick();
      ptick();
      instret_i = 1'b0;
      ptick();
      rd_chk("instret_lo", 12'hB02, 32'h0000_0007);
      rd_chk("instret_mirror", 12'hC02, 32'h0000_0007);
      rd_chk("instret_hi", 12'hC82, 32'd0);
`else
      // Counters absent: addresses read 0 and are legal to read.
      ptick();
      rd_chk("nocnt_b00", 12'hB00, 32'd0);
      ill_chk("nocnt_b00_legal", 1'b0);
      rd_chk("nocnt_c02", 12'hC02, 32'd0);
      ill_chk("nocnt_c02_legal", 1'b0);
      csr_raddr_i = 12'h300;
      wr_start(12'hB00, 32'hFFFF_FFFE);
      #1;
      ill_chk("nocnt_wr_b00_legal", 1'b0);
      ptick();
      wr_end();
      rd_chk("nocnt_b00_after_wr", 12'hB00, 32'd0);
      instret_i = 1'b1;
      ptick();
      instret_i = 1'b0;
      rd_chk("nocnt_b02", 12'hB02, 32'd0);
`endif

      chk_val("sb_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
